// File: rtl/ps_loop_ctrl.sv
// Hardware loop sequencer: a small stack of {start, end, count} loop entries.
// When fetch reaches the top loop's end address it redirects fetch back to the
// loop start, or retires the loop on its last pass.
module ps_loop_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ps_faddr,
  input  logic              ps_idle,
  input  logic              lp_push,
  input  logic [ADDR_W-1:0] lp_start_add,
  input  logic [ADDR_W-1:0] lp_end_add,
  input  logic [CNT_W-1:0]  lp_count,
  input  logic              lp_pop,
  input  logic              lp_clr_ovf,
  output logic              lp_jmp,
  output logic [ADDR_W-1:0] lp_jmp_add,
  output logic [CNT_W-1:0]  lp_cntr,
  output logic              lp_done,
  output logic              lp_stk_empty,
  output logic              lp_stk_full,
  output logic              lp_stk_ovf
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} st_e;

  st_e               st_q, st_d;
  logic [SP_W-1:0]   sp_q, sp_d, sp_post;
  logic [ADDR_W-1:0] start_q [DEPTH];
  logic [ADDR_W-1:0] start_d [DEPTH];
  logic [ADDR_W-1:0] end_q   [DEPTH];
  logic [ADDR_W-1:0] end_d   [DEPTH];
  logic [CNT_W-1:0]  cnt_q   [DEPTH];
  logic [CNT_W-1:0]  cnt_d   [DEPTH];
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [IDX_W-1:0]  top;
  logic              run, empty, match, pop_ok, retire, dec, skip, push_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_EMPTY;
      sp_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      st_q   <= st_d;
      sp_q   <= sp_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        start_q[i] <= start_d[i];
        end_q[i]   <= end_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      start_d[i] = start_q[i];
      end_d[i]   = end_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    top      = (sp_q == '0) ? '0 : IDX_W'(sp_q - 1'b1);
    run      = !ps_idle;
    empty    = (st_q == S_EMPTY);
    match    = run && !empty && (ps_faddr == end_q[top]);
    pop_ok   = run && lp_pop && !empty;
    // An explicit pop beats an end-match on the same entry: no jump, no done.
    retire   = match && (cnt_q[top] == CNT_W'(1)) && !pop_ok;
    dec      = match && (cnt_q[top] >  CNT_W'(1)) && !pop_ok;
    skip     = run && lp_push && (lp_count == '0);
    push_req = run && lp_push && (lp_count != '0);
    sp_post  = sp_q - SP_W'(pop_ok || retire);
    sp_d     = sp_post;
    done_d   = retire;
    ovf_d    = ovf_q && !lp_clr_ovf;

    if (dec) cnt_d[top] = cnt_q[top] - CNT_W'(1);

    // Push lands on the post-pop pointer, so a retire+push reuses the slot.
    if (push_req) begin
      if (sp_post == SP_W'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        start_d[IDX_W'(sp_post)] = lp_start_add;
        end_d[IDX_W'(sp_post)]   = lp_end_add;
        cnt_d[IDX_W'(sp_post)]   = lp_count;
        sp_d                     = sp_post + SP_W'(1);
      end
    end

    if (sp_d == '0)                 st_d = S_EMPTY;
    else if (sp_d == SP_W'(DEPTH))  st_d = S_FULL;
    else                            st_d = S_ACTIVE;

    lp_jmp     = dec || skip;
    lp_jmp_add = '0;
    if (dec)       lp_jmp_add = start_q[top];
    else if (skip) lp_jmp_add = lp_end_add + ADDR_W'(1);
  end

  assign lp_cntr      = empty ? '0 : cnt_q[top];
  assign lp_done      = done_q;
  assign lp_stk_empty = (st_q == S_EMPTY);
  assign lp_stk_full  = (st_q == S_FULL);
  assign lp_stk_ovf   = ovf_q;

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// Directed vector bench for ps_loop_ctrl: table of per-cycle inputs/expected
// outputs plus a hand-written idle-then-async-reset sequence.
module tb_ps_loop_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ps_faddr, lp_start_add, lp_end_add, lp_count;
  logic        ps_idle, lp_push, lp_pop, lp_clr_ovf;
  logic        lp_jmp, lp_done, lp_stk_empty, lp_stk_full, lp_stk_ovf;
  logic [15:0] lp_jmp_add, lp_cntr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps_loop_ctrl #(.ADDR_W(16), .CNT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ps_faddr(ps_faddr), .ps_idle(ps_idle),
    .lp_push(lp_push), .lp_start_add(lp_start_add), .lp_end_add(lp_end_add),
    .lp_count(lp_count), .lp_pop(lp_pop), .lp_clr_ovf(lp_clr_ovf),
    .lp_jmp(lp_jmp), .lp_jmp_add(lp_jmp_add), .lp_cntr(lp_cntr),
    .lp_done(lp_done), .lp_stk_empty(lp_stk_empty), .lp_stk_full(lp_stk_full),
    .lp_stk_ovf(lp_stk_ovf)
  );

  typedef struct {
    logic [15:0] fa;
    logic        idle, push;
    logic [15:0] sa, ea, cnt;
    logic        pop, clr;
    logic        jmp;
    logic [15:0] jadd, cntr;
    logic        done, emp, full, ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic [15:0] fa, input logic idle, push,
                             input logic [15:0] sa, ea, cnt, input logic pop, clr,
                             input logic jmp, input logic [15:0] jadd, cntr,
                             input logic done, emp, full, ovf);
    vec_t r;
    r.fa = fa; r.idle = idle; r.push = push; r.sa = sa; r.ea = ea; r.cnt = cnt;
    r.pop = pop; r.clr = clr; r.jmp = jmp; r.jadd = jadd; r.cntr = cntr;
    r.done = done; r.emp = emp; r.full = full; r.ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic jmp, input logic [15:0] jadd, cntr,
                         input logic done, emp, full, ovf);
    chk("lp_jmp", idx, 32'(lp_jmp), 32'(jmp));
    chk("lp_jmp_add", idx, 32'(lp_jmp_add), 32'(jadd));
    chk("lp_cntr", idx, 32'(lp_cntr), 32'(cntr));
    chk("lp_done", idx, 32'(lp_done), 32'(done));
    chk("lp_stk_empty", idx, 32'(lp_stk_empty), 32'(emp));
    chk("lp_stk_full", idx, 32'(lp_stk_full), 32'(full));
    chk("lp_stk_ovf", idx, 32'(lp_stk_ovf), 32'(ovf));
  endtask

  task automatic drive(input vec_t x);
    ps_faddr = x.fa; ps_idle = x.idle; lp_push = x.push; lp_start_add = x.sa;
    lp_end_add = x.ea; lp_count = x.cnt; lp_pop = x.pop; lp_clr_ovf = x.clr;
  endtask

  initial begin
    vec_t idle_v;
    rst = 1'b1;
    idle_v = v(16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(idle_v);
    #2;
    chk_all(-1, 0, 16'h0, 16'h0, 0, 1, 0, 0);

    // basic loop 0x10..0x12 x3
    vq.push_back(v(16'h0e, 0, 1, 16'h10, 16'h12, 3, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h10, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 3, 0, 0, 0, 0));
    vq.push_back(v(16'h11, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 3, 0, 0, 0, 0));
    vq.push_back(v(16'h12, 0, 0, 0, 0, 0, 0, 0, 1, 16'h10, 3, 0, 0, 0, 0));
    vq.push_back(v(16'h10, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h11, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h12, 0, 0, 0, 0, 0, 0, 0, 1, 16'h10, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h10, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h11, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h12, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h13, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 1, 1, 0, 0));
    vq.push_back(v(16'h14, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    // nested: outer 0x20-0x30 x2, inner 0x22-0x24 x2, repeated
    vq.push_back(v(16'h1f, 0, 1, 16'h20, 16'h30, 2, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h20, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h21, 0, 1, 16'h22, 16'h24, 2, 0, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h22, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h24, 0, 0, 0, 0, 0, 0, 0, 1, 16'h22, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h22, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h24, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h25, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 1, 0, 0, 0));
    vq.push_back(v(16'h30, 0, 0, 0, 0, 0, 0, 0, 1, 16'h20, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h20, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h21, 0, 1, 16'h22, 16'h24, 2, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h24, 0, 0, 0, 0, 0, 0, 0, 1, 16'h22, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h24, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h25, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 1, 0, 0, 0));
    vq.push_back(v(16'h30, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h31, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 1, 1, 0, 0));
    // fill to full, overflow, sticky clear, set-wins-over-clear, drain
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h100, 5, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h101, 6, 0, 0, 0, 16'h00, 5, 0, 0, 0, 0));
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h102, 7, 0, 0, 0, 16'h00, 6, 0, 0, 0, 0));
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h103, 8, 0, 0, 0, 16'h00, 7, 0, 0, 0, 0));
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h104, 9, 0, 0, 0, 16'h00, 8, 0, 0, 1, 0));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 8, 0, 0, 1, 1));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 8, 0, 0, 1, 1));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 0, 1, 0, 16'h00, 8, 0, 0, 1, 1));
    vq.push_back(v(16'hff, 0, 1, 16'h100, 16'h104, 9, 0, 1, 0, 16'h00, 8, 0, 0, 1, 0));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 8, 0, 0, 1, 1));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 1, 1, 0, 16'h00, 7, 0, 0, 0, 1));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 6, 0, 0, 0, 0));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 5, 0, 0, 0, 0));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'hff, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    // zero-count skip, including address wrap
    vq.push_back(v(16'h3f, 0, 1, 16'h00, 16'h40, 0, 0, 0, 1, 16'h41, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h41, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h42, 0, 1, 16'h00, 16'hffff, 0, 0, 0, 1, 16'h00, 0, 0, 1, 0, 0));
    // single-instruction loop at 0x50 x4
    vq.push_back(v(16'h4f, 0, 1, 16'h50, 16'h50, 4, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h50, 0, 0, 0, 0, 0, 0, 0, 1, 16'h50, 4, 0, 0, 0, 0));
    vq.push_back(v(16'h50, 0, 0, 0, 0, 0, 0, 0, 1, 16'h50, 3, 0, 0, 0, 0));
    vq.push_back(v(16'h50, 0, 0, 0, 0, 0, 0, 0, 1, 16'h50, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h50, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h51, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 1, 1, 0, 0));
    // pop beats end-match
    vq.push_back(v(16'h5f, 0, 1, 16'h60, 16'h62, 3, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h62, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 3, 0, 0, 0, 0));
    vq.push_back(v(16'h63, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    // retire + push replaces slot
    vq.push_back(v(16'h6f, 0, 1, 16'h70, 16'h71, 1, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h71, 0, 1, 16'h80, 16'h90, 2, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0));
    vq.push_back(v(16'h72, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 2, 1, 0, 0, 0));
    vq.push_back(v(16'h73, 0, 0, 0, 0, 0, 1, 0, 0, 16'h00, 2, 0, 0, 0, 0));
    vq.push_back(v(16'h74, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    // idle blocks push
    vq.push_back(v(16'h7f, 1, 1, 16'h10, 16'h12, 3, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));
    vq.push_back(v(16'h7f, 0, 0, 0, 0, 0, 0, 0, 0, 16'h00, 0, 0, 1, 0, 0));

    @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk_all(i, vq[i].jmp, vq[i].jadd, vq[i].cntr, vq[i].done, vq[i].emp, vq[i].full, vq[i].ovf);
    end

    // idle at end address freezes the loop, then async reset mid-cycle
    @(negedge clk);
    drive(v(16'h00, 0, 1, 16'h10, 16'h12, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(v(16'h12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk_all(1000, 0, 16'h0, 16'd2, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_all(1001, 0, 16'h0, 16'd2, 0, 0, 0, 0);
    @(negedge clk);
    ps_idle = 1'b0;
    #1;
    chk_all(1002, 1, 16'h10, 16'd2, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk_all(1003, 0, 16'h0, 16'h0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk_all(1004, 0, 16'h0, 16'h0, 0, 1, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_all(1005, 0, 16'h0, 16'h0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
